// File: rtl/decode_display_ctrl.sv
// LED-bank result controller: captures decoder words on done rise and
// shows data, parity or popcount, with a debounced button cycling the mode.
module decode_display_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb,
  input  logic             done,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             result_valid
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DATA     = 2'd0,
    S_PARITY   = 2'd1,
    S_POPCOUNT = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          pb_meta, pb_sync;
  logic          pb_stable, pb_stable_d;
  logic [CW-1:0] cnt;
  logic          press;

  logic             done_d;
  logic             cap;
  logic [WIDTH-1:0] data_reg;
  logic             parity_reg;
  logic [PW-1:0]    pop_reg;
  logic [PW-1:0]    pop_in;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p = p + PW'(d[i]);
    end
    return p;
  endfunction

  assign pop_in = popcount(data_in);
  assign press  = pb_stable & ~pb_stable_d;
  assign cap    = done & ~done_d;
  assign mode   = state_q;

  // A level change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples that differ from pb_stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_meta     <= 1'b0;
      pb_sync     <= 1'b0;
      pb_stable   <= 1'b0;
      pb_stable_d <= 1'b0;
      cnt         <= '0;
    end else begin
      pb_meta     <= pb;
      pb_sync     <= pb_meta;
      pb_stable_d <= pb_stable;
      if (pb_sync == pb_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pb_stable <= pb_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (press) begin
      unique case (state_q)
        S_DATA:     state_d = S_PARITY;
        S_PARITY:   state_d = S_POPCOUNT;
        S_POPCOUNT: state_d = S_HOLD;
        S_HOLD:     state_d = S_DATA;
        default:    state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_d       <= 1'b0;
      data_reg     <= '0;
      parity_reg   <= 1'b0;
      pop_reg      <= '0;
      result_valid <= 1'b0;
    end else begin
      done_d <= done;
      if (cap) begin
        data_reg     <= data_in;
        parity_reg   <= ^data_in;
        pop_reg      <= pop_in;
        result_valid <= 1'b1;
      end
    end
  end

  // HOLD takes priority so a first capture made in HOLD stays dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (state_q == S_HOLD) begin
      led <= led;
    end else if (!result_valid) begin
      led <= '0;
    end else begin
      unique case (state_q)
        S_DATA:     led <= data_reg;
        S_PARITY:   led <= WIDTH'(parity_reg);
        S_POPCOUNT: led <= WIDTH'(pop_reg);
        default:    led <= led;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_display_ctrl.sv
// Directed bench for decode_display_ctrl: capture, mode cycling,
// debounce, HOLD behaviour and reset with done held high.
module tb_decode_display_ctrl;

  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pb;
  logic             done;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] led;
  logic [1:0]       mode;
  logic             result_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  decode_display_ctrl #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb(pb),
    .done(done),
    .data_in(data_in),
    .led(led),
    .mode(mode),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_led,
                         input logic [1:0] e_mode, input logic e_rv);
    check({tag, ".led"}, 32'(led), 32'(e_led));
    check({tag, ".mode"}, 32'(mode), 32'(e_mode));
    check({tag, ".rv"}, 32'(result_valid), 32'(e_rv));
  endtask

  task automatic press_btn();
    pb = 1'b1;
    step(12);
    pb = 1'b0;
    step(12);
  endtask

  initial begin
    rst = 1'b1; pb = 1'b0; done = 1'b0; data_in = '0;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all("reset", 8'h00, 2'd0, 1'b0);
    end
    rst = 1'b0;
    step(2);
    chk_all("idle", 8'h00, 2'd0, 1'b0);

    // 2: capture with 2-cycle latency, single capture while done high
    data_in = 8'hB5; done = 1'b1;
    step(1);
    chk_all("cap+1", 8'h00, 2'd0, 1'b1);
    step(1);
    check("cap+2.led", 32'(led), 32'h0000_00B5);
    data_in = 8'h33;
    step(17);
    check("held.led", 32'(led), 32'h0000_00B5);
    done = 1'b0;
    step(3);
    check("done_low.led", 32'(led), 32'h0000_00B5);

    // 3: mode cycling
    press_btn();
    chk_all("parity", 8'h01, 2'd1, 1'b1);
    press_btn();
    chk_all("popcnt", 8'h05, 2'd2, 1'b1);
    press_btn();
    chk_all("hold", 8'h05, 2'd3, 1'b1);

    // 4: capture in HOLD then leave HOLD
    data_in = 8'h0F; done = 1'b1;
    step(1);
    done = 1'b0;
    step(4);
    chk_all("hold_cap", 8'h05, 2'd3, 1'b1);
    press_btn();
    chk_all("data_new", 8'h0F, 2'd0, 1'b1);

    // 5: debounce - short glitch, long press with bouncy release
    pb = 1'b1;
    step(DB - 1);
    pb = 1'b0;
    step(12);
    chk_all("glitch", 8'h0F, 2'd0, 1'b1);
    pb = 1'b1;
    step(DB + 2 + 2);
    pb = 1'b0; step(1);
    pb = 1'b1; step(1);
    pb = 1'b0; step(1);
    pb = 1'b1; step(2);
    pb = 1'b0;
    step(15);
    chk_all("one_step", 8'h00, 2'd1, 1'b1);
    press_btn();
    chk_all("pop0F", 8'h04, 2'd2, 1'b1);

    // 6: reset in POPCOUNT with done high, then recapture
    data_in = 8'hA3; done = 1'b1; rst = 1'b1;
    step(1);
    chk_all("rst_mid", 8'h00, 2'd0, 1'b0);
    rst = 1'b0;
    step(1);
    chk_all("recap+1", 8'h00, 2'd0, 1'b1);
    step(1);
    chk_all("recap+2", 8'hA3, 2'd0, 1'b1);
    done = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
